// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the core-memory arbiter.
//   word_t       12-bit memory word
//   arb_state_t  arbiter FSM states (arb_idle, arb_access, arb_resp)
//   owner_t      owner of the access in flight (own_cpu, own_dma)
//   sat_inc4     saturating increment for the 4-bit break counter
package mem_arbiter_pkg;

    localparam int WORD_W  = 12;
    localparam int BREAK_W = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        arb_idle   = 2'd0,
        arb_access = 2'd1,
        arb_resp   = 2'd2
    } arb_state_t;

    typedef enum logic {
        own_cpu = 1'b0,
        own_dma = 1'b1
    } owner_t;

    function automatic logic [BREAK_W-1:0] sat_inc4(input logic [BREAK_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: down-counting access watchdog.
//   clk, rst_n  clock, async active-low reset
//   clear       force the counter to zero
//   load        preload TIMEOUT-1 (issued on the grant edge)
//   enable      count down one step per cycle while the access is open
//   expired     high in the TIMEOUT-th enabled cycle after a load
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= W'(TIMEOUT - 1);
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Loaded with TIMEOUT-1 on grant, so zero is reached in the
    // TIMEOUT-th cycle of the access.
    assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 4K x 12 memory port between the CPU sequencer
// and the data-break (DMA) requester.
//   clk, rst_n                 clock, async active-low reset
//   cpu_read/cpu_write         CPU level request (both high = read)
//   cpu_addr/cpu_wdata         CPU address / write data
//   cpu_rdata/cpu_valid        CPU read data and completion pulse
//   dma_req/dma_we             DMA level request and direction
//   dma_addr/dma_wdata         DMA address / write data
//   dma_rdata/dma_valid        DMA read data and completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  memory port command
//   mem_rdata/mem_ack          memory return data and completion
//   mem_err                    pulse with a *_valid that ended in timeout
//   dbg_state                  current arbiter state
//
// Handshake: a requester raises its request level and holds it (with
// stable address/data) until it sees its one-cycle *_valid; the request is
// sampled only in IDLE, so dropping it before a grant cancels it cleanly.
// On the memory side mem_req stays high with stable command fields until
// mem_ack is seen; mem_ack outside ACCESS is ignored.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BREAK = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [11:0] cpu_addr,
    input  logic [11:0] cpu_wdata,
    output logic [11:0] cpu_rdata,
    output logic        cpu_valid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [11:0] dma_addr,
    input  logic [11:0] dma_wdata,
    output logic [11:0] dma_rdata,
    output logic        dma_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_err,
    output arb_state_t  dbg_state
);

    localparam logic [BREAK_W-1:0] MAX_BREAK_V = BREAK_W'(MAX_BREAK);

    arb_state_t           state_q, state_d;
    owner_t               owner_q;
    logic                 we_q;
    word_t                addr_q, wdata_q;
    logic                 err_q;
    logic [BREAK_W-1:0]   break_cnt_q;
    word_t                cpu_rdata_q, dma_rdata_q;

    logic cpu_req, grant_dma, grant_any;
    logic wd_clear, wd_load, wd_enable, wd_expired;

    assign cpu_req   = cpu_read | cpu_write;
    // DMA wins unless the CPU is waiting and has already lost MAX_BREAK
    // consecutive arbitrations.
    assign grant_dma = dma_req && (!cpu_req || (break_cnt_q < MAX_BREAK_V));
    assign grant_any = cpu_req || dma_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= arb_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wd_clear  = 1'b0;
        wd_load   = 1'b0;
        wd_enable = 1'b0;
        case (state_q)
            arb_idle: begin
                if (grant_any) begin
                    state_d = arb_access;
                    wd_load = 1'b1;
                end
            end
            arb_access: begin
                wd_enable = 1'b1;
                if (mem_ack || wd_expired) begin
                    state_d = arb_resp;
                end
            end
            arb_resp: begin
                wd_clear = 1'b1;
                state_d  = arb_idle;
            end
            default: begin
                wd_clear = 1'b1;
                state_d  = arb_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= own_cpu;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            break_cnt_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state_q)
                arb_idle: begin
                    if (grant_any) begin
                        err_q <= 1'b0;
                        if (grant_dma) begin
                            owner_q     <= own_dma;
                            we_q        <= dma_we;
                            addr_q      <= dma_addr;
                            wdata_q     <= dma_wdata;
                            break_cnt_q <= cpu_req ? sat_inc4(break_cnt_q) : '0;
                        end else begin
                            owner_q     <= own_cpu;
                            // Read has precedence when both strobes are up.
                            we_q        <= cpu_write & ~cpu_read;
                            addr_q      <= cpu_addr;
                            wdata_q     <= cpu_wdata;
                            break_cnt_q <= '0;
                        end
                    end
                end
                arb_access: begin
                    if (mem_ack) begin
                        // Writes leave the owner's read-data register alone.
                        if (!we_q) begin
                            if (owner_q == own_dma) dma_rdata_q <= mem_rdata;
                            else                    cpu_rdata_q <= mem_rdata;
                        end
                    end else if (wd_expired) begin
                        err_q <= 1'b1;
                        if (owner_q == own_dma) dma_rdata_q <= '0;
                        else                    cpu_rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .load    (wd_load),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Every output is decoded from state and latches only.
    assign mem_req   = (state_q == arb_access);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_valid = (state_q == arb_resp) && (owner_q == own_cpu);
    assign dma_valid = (state_q == arb_resp) && (owner_q == own_dma);
    assign mem_err   = (state_q == arb_resp) && err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with scoreboard queues
// for memory accesses (start cycle, we, addr, wdata) and for CPU / DMA
// completions (cycle, err, rdata).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic [11:0] cpu_addr = '0, cpu_wdata = '0;
    logic [11:0] cpu_rdata;
    logic        cpu_valid;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [11:0] dma_addr = '0, dma_wdata = '0;
    logic [11:0] dma_rdata;
    logic        dma_valid;
    logic        mem_req, mem_we, mem_err;
    logic [11:0] mem_addr, mem_wdata;
    logic [11:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    arb_state_t  dbg_state;

    mem_arbiter #(.MAX_BREAK(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid),
        .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_valid(dma_valid),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_err(mem_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int errors  = 0;

    logic [40:0] acc_exp_q[$];   // {cycle16, we, addr, wdata}
    logic [28:0] cpu_exp_q[$];   // {cycle16, err, rdata}
    logic [28:0] dma_exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void exp_acc(input int c, input logic we, input logic [11:0] a, input logic [11:0] w);
        acc_exp_q.push_back({16'(c), we, a, w});
    endfunction

    function automatic void exp_cpu(input int c, input logic err, input logic [11:0] d);
        cpu_exp_q.push_back({16'(c), err, d});
    endfunction

    function automatic void exp_dma(input int c, input logic err, input logic [11:0] d);
        dma_exp_q.push_back({16'(c), err, d});
    endfunction

    // ---------------- memory responder ----------------
    logic        never_ack = 1'b0;
    logic        stray_ack = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic [11:0] resp_data = '0;

    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack   = !never_ack && (wait_cnt == ack_delay);
            mem_rdata = mem_ack ? resp_data : 12'h000;
            wait_cnt++;
        end else begin
            mem_ack   = stray_ack;
            mem_rdata = stray_ack ? 12'o7777 : 12'h000;
            wait_cnt  = 0;
        end
    end

    // ---------------- monitors ----------------
    logic        prev_req = 1'b0;
    logic [40:0] cur_acc  = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req && !prev_req) begin
                check("acc_expected", 64'(acc_exp_q.size() > 0), 64'd1);
                if (acc_exp_q.size() > 0) begin
                    cur_acc = acc_exp_q.pop_front();
                    check("acc_start", {16'(cyc), mem_we, mem_addr, mem_wdata}, cur_acc);
                end
            end else if (mem_req) begin
                check("acc_hold", {mem_we, mem_addr, mem_wdata}, cur_acc[24:0]);
            end
            if (cpu_valid) begin
                check("cpu_expected", 64'(cpu_exp_q.size() > 0), 64'd1);
                if (cpu_exp_q.size() > 0)
                    check("cpu_resp", {16'(cyc), mem_err, cpu_rdata}, cpu_exp_q.pop_front());
            end
            if (dma_valid) begin
                check("dma_expected", 64'(dma_exp_q.size() > 0), 64'd1);
                if (dma_exp_q.size() > 0)
                    check("dma_resp", {16'(cyc), mem_err, dma_rdata}, dma_exp_q.pop_front());
            end
            if (mem_err)
                check("mem_err_with_valid", 64'(cpu_valid | dma_valid), 64'd1);
        end
        prev_req = mem_req;
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_do(input logic rd, input logic wr, input logic [11:0] a, input logic [11:0] w);
        int n;
        cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = w;
        n = 0;
        @(negedge clk);
        while (!cpu_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cpu_done_in_time", 64'(n < 200), 64'd1);
        next_cycle();
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic dma_do(input logic we, input logic [11:0] a, input logic [11:0] w);
        int n;
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = w;
        n = 0;
        @(negedge clk);
        while (!dma_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("dma_done_in_time", 64'(n < 200), 64'd1);
        next_cycle();
        dma_req = 1'b0;
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({cpu_rdata, cpu_valid, dma_rdata, dma_valid, mem_req,
                    mem_we, mem_addr, mem_wdata, mem_err});
    endfunction

    // ---------------- directed vectors ----------------
    int t0;
    int n;
    int k;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(arb_idle));
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // zero-wait CPU read
        t0 = cyc;
        resp_data = 12'o7402;
        exp_acc(t0 + 1, 1'b0, 12'o0200, 12'o0000);
        exp_cpu(t0 + 2, 1'b0, 12'o7402);
        cpu_do(1'b1, 1'b0, 12'o0200, 12'o0000);
        next_cycle();

        // simultaneous CPU write and DMA read: DMA first, CPU write at +4
        t0 = cyc;
        resp_data = 12'o6060;
        exp_acc(t0 + 1, 1'b0, 12'o0300, 12'o0000);
        exp_dma(t0 + 2, 1'b0, 12'o6060);
        exp_acc(t0 + 4, 1'b1, 12'o0100, 12'o1234);
        exp_cpu(t0 + 5, 1'b0, 12'o7402);
        fork
            cpu_do(1'b0, 1'b1, 12'o0100, 12'o1234);
            dma_do(1'b0, 12'o0300, 12'o0000);
        join
        next_cycle();

        // DMA held, CPU reading: 4 DMA grants then 1 CPU grant, 15-cycle period
        t0 = cyc;
        resp_data = 12'o5555;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) begin
                exp_acc(t0 + 1 + 3 * i, 1'b0, 12'o0010, 12'o0000);
                exp_cpu(t0 + 2 + 3 * i, 1'b0, 12'o5555);
            end else begin
                exp_acc(t0 + 1 + 3 * i, 1'b0, 12'o0400, 12'o0000);
                exp_dma(t0 + 2 + 3 * i, 1'b0, 12'o5555);
            end
        end
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'o0400; dma_wdata = 12'o0000;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 12'o0010; cpu_wdata = 12'o0000;
        n = 0; k = 0;
        while (k < 2 && n < 100) begin
            @(negedge clk);
            if (cpu_valid) k++;
            n++;
        end
        check("starve_cpu_progress", 64'(k), 64'd2);
        next_cycle();
        dma_req = 1'b0; cpu_read = 1'b0;
        next_cycle();

        // memory never acks: mem_req 64 cycles, valid+err at +65, rdata 0
        t0 = cyc;
        never_ack = 1'b1;
        exp_acc(t0 + 1, 1'b0, 12'o0777, 12'o0000);
        exp_cpu(t0 + 65, 1'b1, 12'o0000);
        cpu_do(1'b1, 1'b0, 12'o0777, 12'o0000);
        never_ack = 1'b0;
        next_cycle();

        // read and write both high -> read access; also next request after timeout
        t0 = cyc;
        resp_data = 12'o2222;
        exp_acc(t0 + 1, 1'b0, 12'o0040, 12'o1111);
        exp_cpu(t0 + 2, 1'b0, 12'o2222);
        cpu_do(1'b1, 1'b1, 12'o0040, 12'o1111);
        next_cycle();

        // DMA write, 3-cycle ack delay: valid at +5, dma_rdata keeps old read
        t0 = cyc;
        ack_delay = 3;
        resp_data = 12'o4321;
        exp_acc(t0 + 1, 1'b1, 12'o0500, 12'o3333);
        exp_dma(t0 + 5, 1'b0, 12'o5555);
        dma_do(1'b1, 12'o0500, 12'o3333);
        ack_delay = 0;
        next_cycle();

        // stray mem_ack while idle is ignored
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_ack_idle", 64'(dbg_state), 64'(arb_idle));
        end
        stray_ack = 1'b0;
        next_cycle();

        // reset asserted in ACCESS cycle 3
        t0 = cyc;
        never_ack = 1'b1;
        exp_acc(t0 + 1, 1'b0, 12'o0123, 12'o0000);
        cpu_read = 1'b1; cpu_addr = 12'o0123; cpu_wdata = 12'o0000;
        repeat (3) @(posedge clk);
        #1;
        check("access_before_reset", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        cpu_read = 1'b0;
        #1;
        check("reset_async_mem_req", 64'(mem_req), 64'd0);
        check("reset_async_outputs", all_outputs(), 64'd0);
        never_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_state", 64'(dbg_state), 64'(arb_idle));
            check("post_reset_outputs", all_outputs(), 64'd0);
        end

        // everything expected was seen
        check("acc_queue_drained", 64'(acc_exp_q.size()), 64'd0);
        check("cpu_queue_drained", 64'(cpu_exp_q.size()), 64'd0);
        check("dma_queue_drained", 64'(dma_exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
